impulse_scheduler: RTL and testbench
====================================

IMPULSE_SCHEDULER -- requirements
Module: impulse_scheduler

Interface
REQ-001 Parameters SHALL be: TIME_W, 64, system-time width; FREQ_W, 48, frequency-word width.
REQ-002 Clock and reset SHALL be fixed: one clock, asynchronous active-low reset.
- clk  in  1  system clock (48 MHz)
- rst_n  in  1  asynchronous active-low reset
REQ-003 Inputs SHALL be:
- clk_en  in  1  tick enable; counters advance only when 1
- SPI_WR  in  1  one-clk strobe: new parameter frame valid
- SYS_TIME  in  TIME_W  running system time, clk-domain
- FREQ, FREQ_STEP  in  FREQ_W  start frequency, per-pulse increment
- TIME_START  in  TIME_W  start time
- N_impulse  in  16  pulse count
- Interval_Ti, Interval_Tp  in  32  pulse width, period (ticks)
- Tblank1, Tblank2  in  32  blank window start/end (ticks from pulse start)
REQ-004 Outputs SHALL be:
- IMP  out  1  pulse gate
- BLANK  out  1  receiver blank gate
- FREQ_OUT  out  FREQ_W  current-pulse frequency word
- IMP_CNT  out  16  index of current pulse
- BUSY  out  1  state != IDLE
- DONE  out  1  one-clk strobe after last pulse period
- REJECT  out  1  one-clk strobe: frame refused

Function
REQ-005 States SHALL be IDLE, ARMED, PULSE, GAP; all outputs registered.
REQ-006 IDLE + SPI_WR SHALL latch all parameter inputs and go ARMED, unless N_impulse==0 or Interval_Tp==0, which SHALL pulse REJECT and stay IDLE.
REQ-007 ARMED + SPI_WR SHALL re-latch parameters (re-arm) with the same validity check; an invalid frame SHALL pulse REJECT and return to IDLE.
REQ-008 ARMED SHALL go to PULSE in the first clk_en cycle where SYS_TIME >= latched TIME_START (unsigned); a start time already passed SHALL start at the next clk_en cycle.
REQ-009 IMP SHALL rise on the clk edge following the qualifying cycle; period counter cleared, IMP_CNT=0, FREQ_OUT=FREQ.
REQ-010 A 32-bit period counter SHALL increment per clk_en tick from pulse start; IMP=1 while counter < min(Interval_Ti, Interval_Tp-1), then GAP.
REQ-011 Interval_Ti==0 SHALL produce no IMP high but still run the full period; Interval_Ti >= Interval_Tp SHALL clamp to Tp-1 ticks.
REQ-012 BLANK SHALL be 1 while Tblank1 <= counter < Tblank2; Tblank2 <= Tblank1 SHALL never assert BLANK.
REQ-013 When counter reaches Interval_Tp-1 on a clk_en tick: if IMP_CNT==N_impulse-1 SHALL go IDLE with DONE strobe and IMP=BLANK=0; otherwise IMP_CNT+1, counter 0, FREQ_OUT += FREQ_STEP (mod 2^FREQ_W), enter PULSE.
REQ-014 SPI_WR in PULSE/GAP SHALL be ignored and pulse REJECT; the running sequence is not disturbed.
REQ-015 clk_en=0 SHALL freeze all counters and state; outputs hold.

Reset
REQ-016 rst_n low SHALL force IDLE, IMP=BLANK=BUSY=DONE=REJECT=0, FREQ_OUT=0, IMP_CNT=0, latched parameters 0, at any time including mid-sequence; no DONE on exit.

Configuration
REQ-017 With IMPULSE_FREQ_STEP_EN defined, FREQ_OUT SHALL step per REQ-013; without it FREQ_OUT SHALL stay at latched FREQ for all pulses and the adder SHALL be absent.

Structure
REQ-018 Package impulse_pkg SHALL hold the state enum (IDLE, ARMED, PULSE, GAP) and TIME_W/FREQ_W defaults, shared with the SPI receiver.
REQ-019 Sub-module impulse_window (period counter + IMP/BLANK compare) SHALL be instantiated once; FSM and frequency stepping stay at top.

Verification
REQ-020 SYS_TIME=100, TIME_START=200, N=3, Ti=5, Tp=20, clk_en=1 -> IMP rises one clk after SYS_TIME=200, three 5-clk pulses 20 clk apart, DONE once, BUSY falls with DONE.
REQ-021 FREQ=1, FREQ_STEP=2, N=4 -> FREQ_OUT 1,3,5,7 per pulse with macro; constant 1 without.
REQ-022 Tblank1=2, Tblank2=8, Tp=10 -> BLANK high counter 2..7 each period; Tblank1=8, Tblank2=2 -> BLANK never high.
REQ-023 N=0 or Tp=0 frame -> REJECT one clk, BUSY stays 0; SPI_WR during PULSE -> REJECT, IMP_CNT sequence unchanged.
REQ-024 clk_en toggling 1-of-2 with Ti=3 -> IMP high 6 clks; rst_n low mid-GAP -> all outputs 0 immediately, no DONE.
REQ-025 TIME_START=50 with SYS_TIME=1000 at SPI_WR -> PULSE entered at next clk_en cycle after ARMED.

Source files
------------

// File: rtl/impulse_pkg.sv
// impulse_pkg: types and defaults shared by the impulse scheduler and the SPI
// receiver that feeds it.
//   imp_state_e  : scheduler FSM states (IDLE, ARMED, PULSE, GAP)
//   imp_timing_t : latched per-frame timing parameters
//   frame_valid  : frame acceptance check (non-zero pulse count and period)
package impulse_pkg;

  localparam int TIME_W_DEF = 64;
  localparam int FREQ_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } imp_state_e;

  typedef struct packed {
    logic [15:0] n_imp;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } imp_timing_t;

  function automatic logic frame_valid(input logic [15:0] n_imp, input logic [31:0] tp);
    return (n_imp != 16'd0) && (tp != 32'd0);
  endfunction

endpackage

// File: rtl/impulse_scheduler_if.sv
// impulse_scheduler_if: parameter frame, tick enable and pulse outputs of the
// impulse scheduler.
//   slave  : scheduler side (frame/tick in, gates/status out)
//   master : driver side (SPI receiver / test bench)
interface impulse_scheduler_if #(
  parameter int TIME_W = 64,
  parameter int FREQ_W = 48
) ();
  logic              clk_en;
  logic              SPI_WR;
  logic [TIME_W-1:0] SYS_TIME;
  logic [FREQ_W-1:0] FREQ;
  logic [FREQ_W-1:0] FREQ_STEP;
  logic [TIME_W-1:0] TIME_START;
  logic [15:0]       N_impulse;
  logic [31:0]       Interval_Ti;
  logic [31:0]       Interval_Tp;
  logic [31:0]       Tblank1;
  logic [31:0]       Tblank2;
  logic              IMP;
  logic              BLANK;
  logic [FREQ_W-1:0] FREQ_OUT;
  logic [15:0]       IMP_CNT;
  logic              BUSY;
  logic              DONE;
  logic              REJECT;

  modport slave (
    input  clk_en, SPI_WR, SYS_TIME, FREQ, FREQ_STEP, TIME_START, N_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    output IMP, BLANK, FREQ_OUT, IMP_CNT, BUSY, DONE, REJECT
  );

  modport master (
    output clk_en, SPI_WR, SYS_TIME, FREQ, FREQ_STEP, TIME_START, N_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    input  IMP, BLANK, FREQ_OUT, IMP_CNT, BUSY, DONE, REJECT
  );
endinterface

// File: rtl/impulse_window.sv
// impulse_window: per-pulse period counter with registered IMP/BLANK gates.
//   clk, rst_n      : clock, async active-low reset
//   i_start         : begin a new period (counter -> 0)
//   i_adv           : advance counter by one tick
//   i_clr           : sequence finished, drop gates and counter
//   i_ti/i_tp       : pulse width / period in ticks
//   i_tb1/i_tb2     : blank window [tb1, tb2) in ticks from pulse start
//   o_imp, o_blank  : registered gates for the current counter value
//   o_period_end    : counter sits on the last tick of the period (tp-1)
//   o_imp_at0       : IMP value a fresh period will start with
//   o_imp_inc       : IMP value after the next advance
module impulse_window (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_adv,
  input  logic        i_clr,
  input  logic [31:0] i_ti,
  input  logic [31:0] i_tp,
  input  logic [31:0] i_tb1,
  input  logic [31:0] i_tb2,
  output logic        o_imp,
  output logic        o_blank,
  output logic        o_period_end,
  output logic        o_imp_at0,
  output logic        o_imp_inc
);
  logic [31:0] r_cnt;
  logic [31:0] w_tp_m1;
  logic [31:0] w_ti_eff;
  logic [31:0] w_cnt_inc;

  // Pulse is clamped so at least the last tick of the period is low.
  assign w_tp_m1      = i_tp - 32'd1;
  assign w_ti_eff     = (i_ti < w_tp_m1) ? i_ti : w_tp_m1;
  assign w_cnt_inc    = r_cnt + 32'd1;
  assign o_period_end = (r_cnt == w_tp_m1);
  assign o_imp_at0    = (w_ti_eff != 32'd0);
  assign o_imp_inc    = (w_cnt_inc < w_ti_eff);

  // Empty or inverted window never matches.
  function automatic logic in_blank(input logic [31:0] c, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      o_imp   <= 1'b0;
      o_blank <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      o_imp   <= 1'b0;
      o_blank <= 1'b0;
    end else if (i_start) begin
      r_cnt   <= '0;
      o_imp   <= o_imp_at0;
      o_blank <= in_blank(32'd0, i_tb1, i_tb2);
    end else if (i_adv) begin
      r_cnt   <= w_cnt_inc;
      o_imp   <= o_imp_inc;
      o_blank <= in_blank(w_cnt_inc, i_tb1, i_tb2);
    end
  end
endmodule

// File: rtl/impulse_scheduler.sv
// impulse_scheduler: arms on a parameter frame, waits for SYS_TIME to reach
// TIME_START, then emits N_impulse pulses of Interval_Ti ticks every
// Interval_Tp ticks with a receiver blank window per period.
//   clk, rst_n : 48 MHz clock, async active-low reset
//   io (slave) : clk_en tick, SPI_WR frame strobe + parameters in;
//                IMP, BLANK, FREQ_OUT, IMP_CNT, BUSY, DONE, REJECT out
// Build option: IMPULSE_FREQ_STEP_EN adds FREQ_STEP to FREQ_OUT every pulse;
// without it FREQ_OUT holds the latched FREQ and no adder is built.
module impulse_scheduler
  import impulse_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF,
  parameter int FREQ_W = FREQ_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  impulse_scheduler_if.slave io
);
  imp_state_e        r_state, w_state_nxt;
  imp_timing_t       r_tim;
  logic [TIME_W-1:0] r_time_start;
  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] r_freq_out;
  logic [15:0]       r_imp_cnt;
  logic              r_busy, r_done, r_reject;

  logic w_frame_ok, w_last;
  logic w_latch, w_rej, w_start, w_wrap, w_adv, w_finish;
  logic w_imp, w_blank, w_period_end, w_imp_at0, w_imp_inc;

  assign w_frame_ok = frame_valid(io.N_impulse, io.Interval_Tp);
  assign w_last     = (r_imp_cnt == r_tim.n_imp - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_rej       = 1'b0;
    w_start     = 1'b0;
    w_wrap      = 1'b0;
    w_adv       = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (io.SPI_WR) begin
          if (w_frame_ok) begin
            w_latch     = 1'b1;
            w_state_nxt = ARMED;
          end else begin
            w_rej = 1'b1;
          end
        end
      end
      ARMED: begin
        // A new frame takes priority over a start in the same cycle.
        if (io.SPI_WR) begin
          if (w_frame_ok) begin
            w_latch = 1'b1;
          end else begin
            w_rej       = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (io.clk_en && (io.SYS_TIME >= r_time_start)) begin
          w_start     = 1'b1;
          w_state_nxt = w_imp_at0 ? PULSE : GAP;
        end
      end
      PULSE, GAP: begin
        w_rej = io.SPI_WR;
        if (io.clk_en) begin
          if (w_period_end) begin
            if (w_last) begin
              w_finish    = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_wrap      = 1'b1;
              w_start     = 1'b1;
              w_state_nxt = w_imp_at0 ? PULSE : GAP;
            end
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = w_imp_inc ? PULSE : GAP;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef IMPULSE_FREQ_STEP_EN
  logic [FREQ_W-1:0] r_freq_step;
`else
  logic [FREQ_W-1:0] w_unused_freq_step;
  assign w_unused_freq_step = io.FREQ_STEP;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tim        <= '0;
      r_time_start <= '0;
      r_freq       <= '0;
`ifdef IMPULSE_FREQ_STEP_EN
      r_freq_step  <= '0;
`endif
      r_freq_out   <= '0;
      r_imp_cnt    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_finish;
      r_reject <= w_rej;
      if (w_latch) begin
        r_tim.n_imp  <= io.N_impulse;
        r_tim.ti     <= io.Interval_Ti;
        r_tim.tp     <= io.Interval_Tp;
        r_tim.tb1    <= io.Tblank1;
        r_tim.tb2    <= io.Tblank2;
        r_time_start <= io.TIME_START;
        r_freq       <= io.FREQ;
`ifdef IMPULSE_FREQ_STEP_EN
        r_freq_step  <= io.FREQ_STEP;
`endif
      end
      if (w_wrap) begin
        r_imp_cnt  <= r_imp_cnt + 16'd1;
`ifdef IMPULSE_FREQ_STEP_EN
        r_freq_out <= r_freq_out + r_freq_step;
`endif
      end else if (w_start) begin
        r_imp_cnt  <= '0;
        r_freq_out <= r_freq;
      end
    end
  end

  impulse_window u_window (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_adv        (w_adv),
    .i_clr        (w_finish),
    .i_ti         (r_tim.ti),
    .i_tp         (r_tim.tp),
    .i_tb1        (r_tim.tb1),
    .i_tb2        (r_tim.tb2),
    .o_imp        (w_imp),
    .o_blank      (w_blank),
    .o_period_end (w_period_end),
    .o_imp_at0    (w_imp_at0),
    .o_imp_inc    (w_imp_inc)
  );

  assign io.IMP      = w_imp;
  assign io.BLANK    = w_blank;
  assign io.FREQ_OUT = r_freq_out;
  assign io.IMP_CNT  = r_imp_cnt;
  assign io.BUSY     = r_busy;
  assign io.DONE     = r_done;
  assign io.REJECT   = r_reject;
endmodule

// File: tb/tb_impulse_scheduler.sv
// Bench for impulse_scheduler: table of frames driven through a tick-index
// reference model (expected outputs queued per cycle), per-frame totals from
// the table, plus directed re-arm, invalid re-arm and mid-sequence reset.
module tb_impulse_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  impulse_scheduler_if #(.TIME_W(64), .FREQ_W(48)) io ();

  impulse_scheduler #(.TIME_W(64), .FREQ_W(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct packed {
    logic        imp;
    logic        blank;
    logic        busy;
    logic        done;
    logic        reject;
    logic [15:0] cnt;
    logic [47:0] freq;
  } obs_t;

  typedef struct {
    string           name;
    longint unsigned sys0, ts;
    int unsigned     n, ti, tp, tb1, tb2;
    longint unsigned freq, step;
    bit              half;
    int              inj;
    int              e_imp, e_blank, e_done, e_rej;
    longint          e_rise;
  } scn_t;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  // reference model: 0 idle, 1 armed, 2 running (t = ticks since start)
  int              m_st = 0;
  longint unsigned m_t = 0;
  logic [15:0]     m_cnt = '0;
  logic [47:0]     m_freq = '0;

  int     t_imp, t_blank, t_done, t_rej;
  longint t_rise;
  string  cur;

  function automatic obs_t dut_obs();
    obs_t o;
    o.imp = io.IMP; o.blank = io.BLANK; o.busy = io.BUSY; o.done = io.DONE;
    o.reject = io.REJECT; o.cnt = io.IMP_CNT; o.freq = io.FREQ_OUT;
    return o;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit en, input bit spi, input longint unsigned st,
                            input scn_t s);
    obs_t e;
    longint unsigned p, c, tie;
    e = '0;
    case (m_st)
      0: if (spi) begin
           if (s.n != 0 && s.tp != 0) m_st = 1;
           else e.reject = 1'b1;
         end
      1: if (!spi && en && st >= s.ts) begin m_st = 2; m_t = 0; end
      default: begin
        if (spi) e.reject = 1'b1;
        if (en) begin
          m_t++;
          if (m_t == longint'(s.n) * s.tp) begin m_st = 0; e.done = 1'b1; end
        end
      end
    endcase
    if (m_st == 2) begin
      p   = m_t / s.tp;
      c   = m_t % s.tp;
      tie = (s.ti < s.tp - 1) ? s.ti : s.tp - 1;
      e.imp   = (c < tie);
      e.blank = (c >= s.tb1) && (c < s.tb2);
      m_cnt   = 16'(p);
`ifdef IMPULSE_FREQ_STEP_EN
      m_freq  = 48'(s.freq + s.step * p);
`else
      m_freq  = 48'(s.freq);
`endif
    end
    e.busy = (m_st != 0);
    e.cnt  = m_cnt;
    e.freq = m_freq;
    exp_q.push_back(e);
  endtask

  task automatic chk_pop();
    obs_t e, a;
    e = exp_q.pop_front();
    a = dut_obs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL trace %s @sys=%0d: got %h expected %h (imp,blank,busy,done,rej,cnt,freq)",
               cur, io.SYS_TIME, a, e);
    end
    if (a.imp) begin
      t_imp++;
      if (t_rise < 0) t_rise = longint'(io.SYS_TIME);
    end
    if (a.blank)  t_blank++;
    if (a.done)   t_done++;
    if (a.reject) t_rej++;
  endtask

  task automatic scramble();
    io.TIME_START  = {$urandom, $urandom};
    io.FREQ        = {16'($urandom), $urandom};
    io.FREQ_STEP   = {16'($urandom), $urandom};
    io.N_impulse   = 16'($urandom);
    io.Interval_Ti = $urandom;
    io.Interval_Tp = $urandom;
    io.Tblank1     = $urandom;
    io.Tblank2     = $urandom;
  endtask

  task automatic run_scn(input scn_t s);
    int  tail = 0;
    bit  fin = 0;
    cur = s.name;
    t_imp = 0; t_blank = 0; t_done = 0; t_rej = 0; t_rise = -1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (exp_q.size() > 0) chk_pop();
      if (cyc > 0 && m_st == 0) tail++;
      if (tail == 3) fin = 1;
      else begin
        if (cyc == 0) begin
          io.SYS_TIME    = s.sys0;
          io.TIME_START  = s.ts;
          io.N_impulse   = 16'(s.n);
          io.Interval_Ti = s.ti;
          io.Interval_Tp = s.tp;
          io.Tblank1     = s.tb1;
          io.Tblank2     = s.tb2;
          io.FREQ        = 48'(s.freq);
          io.FREQ_STEP   = 48'(s.step);
        end else begin
          io.SYS_TIME = io.SYS_TIME + 64'd1;
          scramble();
        end
        io.clk_en = s.half ? (cyc % 2 == 0) : 1'b1;
        io.SPI_WR = (cyc == 0) || (cyc == s.inj);
        model_step(io.clk_en, io.SPI_WR, io.SYS_TIME, s);
      end
    end
    if (!fin) chk({s.name, " timeout"}, 1, 0);
    io.SPI_WR = 1'b0;
    chk({s.name, " imp_clks"},   t_imp,   s.e_imp);
    chk({s.name, " blank_clks"}, t_blank, s.e_blank);
    chk({s.name, " done_cnt"},   t_done,  s.e_done);
    chk({s.name, " reject_cnt"}, t_rej,   s.e_rej);
    chk({s.name, " rise_time"},  t_rise,  s.e_rise);
  endtask

  function automatic scn_t mk(string nm, longint unsigned sys0, longint unsigned ts,
      int unsigned n, int unsigned ti, int unsigned tp, int unsigned tb1, int unsigned tb2,
      longint unsigned f, longint unsigned st, bit half, int inj,
      int ei, int eb, int ed, int er, longint erise);
    scn_t s;
    s.name = nm; s.sys0 = sys0; s.ts = ts; s.n = n; s.ti = ti; s.tp = tp;
    s.tb1 = tb1; s.tb2 = tb2; s.freq = f; s.step = st; s.half = half; s.inj = inj;
    s.e_imp = ei; s.e_blank = eb; s.e_done = ed; s.e_rej = er; s.e_rise = erise;
    return s;
  endfunction

  task automatic frame(input longint unsigned ts, input int unsigned n, input int unsigned ti,
                       input int unsigned tp);
    io.TIME_START = ts; io.N_impulse = 16'(n); io.Interval_Ti = ti; io.Interval_Tp = tp;
    io.Tblank1 = 0; io.Tblank2 = 0; io.FREQ = 48'd9; io.FREQ_STEP = 48'd1;
    io.SPI_WR = 1'b1;
  endtask

  scn_t tbl[11];
  int   dn, bz;

  initial begin
    io.clk_en = 1'b0; io.SPI_WR = 1'b0; io.SYS_TIME = '0;
    io.TIME_START = '0; io.FREQ = '0; io.FREQ_STEP = '0; io.N_impulse = '0;
    io.Interval_Ti = '0; io.Interval_Tp = '0; io.Tblank1 = '0; io.Tblank2 = '0;

    //            name       sys0  ts   n  ti  tp tb1 tb2  f    st half inj   imp blk dn rj rise
    tbl[0]  = mk("basic",    100, 200, 3,  5, 20, 0, 0,   1,   2, 0, 110,  15, 0,  1, 1, 200);
    tbl[1]  = mk("fstep",    10,  0,   4,  2, 4,  1, 3,   1,   2, 0, -1,   8,  8,  1, 0, 11);
    tbl[2]  = mk("blank",    0,   5,   2,  3, 10, 2, 8,   100, 7, 0, -1,   6,  12, 1, 0, 5);
    tbl[3]  = mk("blank_inv",0,   5,   2,  3, 10, 8, 2,   100, 7, 0, -1,   6,  0,  1, 0, 5);
    tbl[4]  = mk("ti_zero",  0,   0,   2,  0, 5,  0, 5,   3,   1, 0, -1,   0,  10, 1, 0, -1);
    tbl[5]  = mk("ti_clamp", 20,  0,   2, 50, 6,  0, 0,   3,   1, 0, -1,   10, 0,  1, 0, 21);
    tbl[6]  = mk("half_en",  10,  0,   1,  3, 5,  0, 0,   5,   5, 1, -1,   6,  0,  1, 0, 12);
    tbl[7]  = mk("n_zero",   0,   0,   0,  1, 5,  0, 0,   1,   1, 0, -1,   0,  0,  0, 1, -1);
    tbl[8]  = mk("tp_zero",  0,   0,   3,  1, 0,  0, 0,   1,   1, 0, -1,   0,  0,  0, 1, -1);
    tbl[9]  = mk("past",     1000,50,  1,  2, 3,  0, 0,   7,   0, 0, -1,   2,  0,  1, 0, 1001);
    tbl[10] = mk("tp_one",   0,   0,   3,  4, 1,  0, 1,   2,   3, 0, -1,   0,  3,  1, 0, -1);

    // reset state
    @(negedge clk);
    chk("reset_outputs", longint'(dut_obs() != '0), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_scn(tbl[i]);

    // re-arm in ARMED: second frame replaces a far-future start
    @(negedge clk);
    io.clk_en = 1'b1; frame(io.SYS_TIME + 64'd5000, 1, 1, 3);
    @(negedge clk);
    chk("rearm_busy", io.BUSY, 1);
    frame(0, 1, 1, 3);
    @(negedge clk);
    chk("rearm_hold_imp", io.IMP, 0);
    io.SPI_WR = 1'b0;
    @(negedge clk);
    chk("rearm_start_imp", io.IMP, 1);
    bz = 0;
    while (io.BUSY && bz < 20) begin @(negedge clk); bz++; end
    chk("rearm_finish_busy", io.BUSY, 0);

    // invalid re-arm drops back to IDLE
    frame(io.SYS_TIME + 64'd5000, 2, 1, 3);
    @(negedge clk);
    chk("bad_rearm_armed", io.BUSY, 1);
    frame(0, 0, 1, 3);
    @(negedge clk);
    chk("bad_rearm_reject", io.REJECT, 1);
    chk("bad_rearm_busy", io.BUSY, 0);
    io.SPI_WR = 1'b0;
    @(negedge clk);
    chk("bad_rearm_reject_1clk", io.REJECT, 0);

    // asynchronous reset in the gap of the first pulse
    frame(0, 2, 2, 10);
    @(negedge clk);
    io.SPI_WR = 1'b0;
    repeat (4) @(negedge clk);
    chk("gap_imp", io.IMP, 0);
    chk("gap_busy", io.BUSY, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", longint'(dut_obs() != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (io.DONE) dn++;
    end
    chk("post_reset_done", dn, 0);
    chk("post_reset_busy", io.BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
